// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scan controller.
// Segment vectors are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0001100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        BLANKING = 1'b0,
        DRIVE    = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern; purely combinational, zero latency.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller: prescaled digit slots, blanking at slot start, frame-aligned shadow commit; outputs 1 cycle after cnt/dig/state, no backpressure.
// Optional leading-zero suppression enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start,
    output logic        upd_ack
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    dig;
    slot_state_t   state, state_nxt;
    logic          tick, boundary;

    logic [15:0]   shadow_dig, active_dig;
    logic [3:0]    shadow_dp, active_dp;
    logic          pending;

    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg_n;
    logic [3:0]    suppress;
    logic          show;

    assign tick     = (cnt == CW'(DIV - 1));
    assign boundary = tick && (dig == 2'd3);
    assign cnt_nxt  = tick ? '0 : cnt + CW'(1);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign state_nxt = DRIVE;
        end else begin : g_blank
            assign state_nxt = (cnt_nxt < CW'(BLANK)) ? BLANKING : DRIVE;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            dig   <= '0;
            state <= BLANKING;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
            if (tick) begin
                dig <= dig + 2'd1;
            end
        end
    end

    // A load landing on the boundary cycle commits the previous shadow and stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            active_dig <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (boundary && pending) begin
                active_dig <= shadow_dig;
                active_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending    <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; digit 0 is never suppressed.
    always_comb begin
        logic higher_blank;
        logic nib_zero;
        suppress     = '0;
        higher_blank = 1'b1;
        nib_zero     = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            nib_zero = (active_dig[k*4 +: 4] == 4'd0);
            if (nib_zero && !active_dp[k] && higher_blank) begin
                suppress[k] = 1'b1;
            end
            higher_blank = higher_blank && (nib_zero || !digit_en[k]);
        end
    end
`else
    assign suppress = '0;
`endif

    assign cur_nibble = active_dig[{dig, 2'b00} +: 4];
    assign show       = (state == DRIVE) && digit_en[dig] && !suppress[dig];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (cur_seg_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            an_n        <= AN_OFF;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            if (show) begin
                an_n  <= ~(4'b0001 << dig);
                seg_n <= cur_seg_n;
                dp_n  <= ~active_dp[dig];
            end else begin
                an_n  <= AN_OFF;
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
            end
            frame_start <= boundary;
            upd_ack     <= boundary && pending;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=8, BLANK=2 (32 cycles per frame).
module tb_seg7_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b0000001;
    localparam logic [6:0] S_2   = 7'b0010010;
    localparam logic [6:0] S_3   = 7'b0000110;
    localparam logic [6:0] S_5   = 7'b0100100;
    localparam logic [6:0] S_6   = 7'b0100000;
    localparam logic [6:0] S_7   = 7'b0001111;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_F   = 7'b0111000;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;
    logic        upd_ack;

    int n_vec = 0;
    int n_err = 0;
    int pos;      // output position currently visible: dig = pos/8 % 4, cnt = pos % 8
    int ack_cnt = 0;
    int ack_base;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start),
        .upd_ack     (upd_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @pos %0d: got %0h expected %0h", tag, pos, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        pos++;
        if (upd_ack === 1'b1) ack_cnt++;
    endtask

    task automatic run_to(input int m);
        while (pos < m) step();
    endtask

    task automatic expect_disp(input int m, input string tag, input logic [3:0] an,
                               input logic [6:0] seg, input logic dp);
        run_to(m);
        check({tag, ".an"}, 32'(an_n), 32'(an));
        check({tag, ".seg"}, 32'(seg_n), 32'(seg));
        check({tag, ".dp"}, 32'(dp_n), 32'(dp));
    endtask

    // load is sampled by the edge that evaluates position k
    task automatic do_load(input int k, input logic [15:0] d, input logic [3:0] dp);
        run_to(k - 1);
        load      = 1'b1;
        digits_in = d;
        dp_in     = dp;
        step();
        load      = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        digit_en  = 4'b1111;
        pos       = -100;
        repeat (3) @(negedge clk);
        check("rst.an", 32'(an_n), 32'h000f);
        check("rst.seg", 32'(seg_n), 32'(S_OFF));
        check("rst.dp", 32'(dp_n), 32'h1);
        check("rst.fs", 32'(frame_start), 32'h0);
        check("rst.ack", 32'(upd_ack), 32'h0);
        reset = 1'b0;
        pos   = -1;

        // Power-on scan of all-zero value
        expect_disp(0, "p0", 4'b1111, S_OFF, 1'b1);
        expect_disp(1, "p1", 4'b1111, S_OFF, 1'b1);
        expect_disp(2, "p2", 4'b1110, S_0, 1'b1);
        expect_disp(7, "p7", 4'b1110, S_0, 1'b1);
        expect_disp(8, "p8", 4'b1111, S_OFF, 1'b1);

        // Load during digit 1; display must not change until the frame boundary
        do_load(10, 16'h3A7F, 4'b0100);
        expect_disp(10, "old.d1", LZB ? 4'b1111 : 4'b1101, LZB ? S_OFF : S_0, 1'b1);
        expect_disp(18, "old.d2", LZB ? 4'b1111 : 4'b1011, LZB ? S_OFF : S_0, 1'b1);
        run_to(30);
        check("fs.pre", 32'(frame_start), 32'h0);
        check("ack.pre", 32'(upd_ack), 32'h0);
        expect_disp(31, "old.d3", LZB ? 4'b1111 : 4'b0111, LZB ? S_OFF : S_0, 1'b1);
        check("fs.1", 32'(frame_start), 32'h1);
        check("ack.1", 32'(upd_ack), 32'h1);
        run_to(32);
        check("fs.post", 32'(frame_start), 32'h0);
        check("ack.post", 32'(upd_ack), 32'h0);
        expect_disp(34, "new.d0", 4'b1110, S_F, 1'b1);
        expect_disp(42, "new.d1", 4'b1101, S_7, 1'b1);
        expect_disp(50, "new.d2", 4'b1011, S_A, 1'b0);
        expect_disp(58, "new.d3", 4'b0111, S_3, 1'b1);

        // Live digit enable: slot 2 goes dark
        run_to(63);
        digit_en = 4'b1011;
        expect_disp(66, "en.d0", 4'b1110, S_F, 1'b1);
        expect_disp(82, "en.d2", 4'b1111, S_OFF, 1'b1);
        expect_disp(90, "en.d3", 4'b0111, S_3, 1'b1);
        run_to(95);
        digit_en = 4'b1111;
        ack_base = ack_cnt;

        // Two loads in one frame: last wins, single ack
        do_load(100, 16'h1111, 4'b0000);
        do_load(105, 16'h2222, 4'b0000);
        run_to(127);
        check("dbl.ack", 32'(upd_ack), 32'h1);
        expect_disp(130, "dbl.d0", 4'b1110, S_2, 1'b1);
        run_to(159);
        check("dbl.nacks", 32'(ack_cnt - ack_base), 32'h1);

        // Load on the boundary tick commits the older shadow first
        do_load(170, 16'h5555, 4'b0000);
        do_load(191, 16'h6666, 4'b0000);
        check("coll.ack1", 32'(upd_ack), 32'h1);
        expect_disp(194, "coll.d0a", 4'b1110, S_5, 1'b1);
        run_to(223);
        check("coll.ack2", 32'(upd_ack), 32'h1);
        expect_disp(226, "coll.d0b", 4'b1110, S_6, 1'b1);

        // Leading zeros
        do_load(230, 16'h0050, 4'b0000);
        run_to(255);
        check("lz.ack", 32'(upd_ack), 32'h1);
        expect_disp(258, "lz.d0", 4'b1110, S_0, 1'b1);
        expect_disp(266, "lz.d1", 4'b1101, S_5, 1'b1);
        expect_disp(274, "lz.d2", LZB ? 4'b1111 : 4'b1011, LZB ? S_OFF : S_0, 1'b1);
        expect_disp(282, "lz.d3", LZB ? 4'b1111 : 4'b0111, LZB ? S_OFF : S_0, 1'b1);

        // Reset mid-DRIVE with a pending load that must be discarded
        do_load(283, 16'h8888, 4'b0000);
        expect_disp(284, "mid.pre", LZB ? 4'b1111 : 4'b0111, LZB ? S_OFF : S_0, 1'b1);
        reset = 1'b1;
        step();
        expect_disp(pos, "mid.rst", 4'b1111, S_OFF, 1'b1);
        step();
        reset = 1'b0;
        pos   = -1;
        expect_disp(2, "rr.d0", 4'b1110, S_0, 1'b1);
        run_to(31);
        check("rr.fs", 32'(frame_start), 32'h1);
        check("rr.ack", 32'(upd_ack), 32'h0);
        expect_disp(34, "rr.d0b", 4'b1110, S_0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
